mlp_layer_sequencer: RTL

Parametrised top-level sequencer for the MLP inference datapath. It steps the shared processing-unit (PU) array through N_TESTS samples. For each sample it runs HID_GROUPS hidden-layer neuron groups, then OUT_GROUPS output-layer groups, and raises per-group load strobes for the layer registers. It adds three things the earlier controller lacked: configurable group and test counts, a start-pulse mode, and a synchronous abort.

---
 rtl/mlp_pkg.sv | 28 ++
 rtl/mlp_group_counter.sv | 33 +++
 rtl/mlp_layer_sequencer.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/mlp_pkg.sv
// mlp_pkg: shared types and defaults for the MLP layer sequencer.
//   mlp_state_t : sequencer state encoding (IDLE=0, READ=1, HID=2, OUT=3)
//   cnt_ctl_t   : load-zero / increment controls for mlp_group_counter
//   *_DEF       : default sample and group counts
//   max2        : larger of two ints, used to size the group index
package mlp_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_READ = 2'd1,
        ST_HID  = 2'd2,
        ST_OUT  = 2'd3
    } mlp_state_t;

    typedef struct packed {
        logic clr;
        logic inc;
    } cnt_ctl_t;

    localparam int N_TESTS_DEF    = 750;
    localparam int HID_GROUPS_DEF = 4;
    localparam int OUT_GROUPS_DEF = 2;

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/mlp_group_counter.sv
// mlp_group_counter: up-counter with synchronous load-zero and a
// terminal-count compare against a (possibly run-time) terminal value.
//   clk, rst : clock, asynchronous active-low reset
//   ctl      : clr (load zero, wins) / inc (count up)
//   term     : terminal value compared against the count
//   count    : current count
//   at_term  : count == term
module mlp_group_counter
    import mlp_pkg::*;
#(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  cnt_ctl_t     ctl,
    input  logic [W-1:0] term,
    output logic [W-1:0] count,
    output logic         at_term
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
        end else if (ctl.clr) begin
            count <= '0;
        end else if (ctl.inc) begin
            count <= count + W'(1);
        end
    end

    assign at_term = (count == term);

endmodule

// File: rtl/mlp_layer_sequencer.sv
// mlp_layer_sequencer: steps the shared PU array through N_TESTS samples,
// each as one READ cycle, HID_GROUPS hidden groups and OUT_GROUPS output
// groups, with one-hot load strobes for the layer register banks.
//
// Ports:
//   clk, rst          clock, asynchronous active-low reset
//   start             begin a run (IDLE only; beats abort there)
//   abort             synchronous abort in READ/HID/OUT (beats ready_pu)
//   ready_pu          PU array finished the current group
//   start_pu          PU launch (level or entry pulse, see START_PULSE)
//   rd_sample         fetch sample test_index
//   ld_hidden_layer   one-hot hidden bank load strobe
//   ld_output_layer   one-hot output bank load strobe
//   test_index        sample being processed / progress after abort
//   group_index       group running within the current layer
//   single_test_done  one-cycle registered pulse per finished sample
//   done              high in IDLE
//   aborted           sticky: last run ended by abort
//   timeout_err       sticky watchdog flag
//
// Optional build macro MLP_SEQ_TIMEOUT_EN adds a per-group watchdog; without
// it no counter is built and timeout_err is tied low.
module mlp_layer_sequencer
    import mlp_pkg::*;
#(
    parameter int N_TESTS        = N_TESTS_DEF,
    parameter int HID_GROUPS     = HID_GROUPS_DEF,
    parameter int OUT_GROUPS     = OUT_GROUPS_DEF,
    parameter int START_PULSE    = 0,
    parameter int TIMEOUT_CYCLES = 1023,
    parameter int IDX_W          = $clog2(N_TESTS + 1),
    parameter int GRP_W          = $clog2(max2(HID_GROUPS, OUT_GROUPS) + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  abort,
    input  logic                  ready_pu,
    output logic                  start_pu,
    output logic                  rd_sample,
    output logic [HID_GROUPS-1:0] ld_hidden_layer,
    output logic [OUT_GROUPS-1:0] ld_output_layer,
    output logic [IDX_W-1:0]      test_index,
    output logic [GRP_W-1:0]      group_index,
    output logic                  single_test_done,
    output logic                  done,
    output logic                  aborted,
    output logic                  timeout_err
);

    mlp_state_t state, state_nxt;

    cnt_ctl_t   grp_ctl, tst_ctl;
    logic [GRP_W-1:0] grp_term;
    logic       grp_last;
    logic       tst_end;

    logic       entry_nxt;   // next cycle is the first cycle of a group
    logic       first_q;     // current cycle is the first cycle of a group
    logic       stdone_nxt;
    logic       abort_set;
    logic       run_clr;     // start accepted: clear sticky status
    logic       wd_hit;
`ifdef MLP_SEQ_TIMEOUT_EN
    logic       tmo_set;
`endif

    // Terminal group depends on which layer is running.
    assign grp_term = (state == ST_OUT) ? GRP_W'(OUT_GROUPS - 1)
                                        : GRP_W'(HID_GROUPS - 1);

    mlp_group_counter #(.W(GRP_W)) u_grp_cnt (
        .clk     (clk),
        .rst     (rst),
        .ctl     (grp_ctl),
        .term    (grp_term),
        .count   (group_index),
        .at_term (grp_last)
    );

    mlp_group_counter #(.W(IDX_W)) u_tst_cnt (
        .clk     (clk),
        .rst     (rst),
        .ctl     (tst_ctl),
        .term    (IDX_W'(N_TESTS)),
        .count   (test_index),
        .at_term (tst_end)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state            <= ST_IDLE;
            first_q          <= 1'b0;
            single_test_done <= 1'b0;
            aborted          <= 1'b0;
        end else begin
            state            <= state_nxt;
            first_q          <= entry_nxt;
            single_test_done <= stdone_nxt;
            if (run_clr) begin
                aborted <= 1'b0;
            end else if (abort_set) begin
                aborted <= 1'b1;
            end
        end
    end

`ifdef MLP_SEQ_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [WD_W-1:0] wd_cnt;   // cycles already spent in the current group

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wd_cnt      <= '0;
            timeout_err <= 1'b0;
        end else begin
            if (entry_nxt) begin
                wd_cnt <= '0;
            end else if (state == ST_HID || state == ST_OUT) begin
                wd_cnt <= wd_cnt + WD_W'(1);
            end
            if (run_clr) begin
                timeout_err <= 1'b0;
            end else if (tmo_set) begin
                timeout_err <= 1'b1;
            end
        end
    end

    assign wd_hit = (wd_cnt == WD_W'(TIMEOUT_CYCLES - 1));
`else
    assign wd_hit      = 1'b0;
    assign timeout_err = 1'b0;
`endif

    always_comb begin
        state_nxt       = state;
        grp_ctl         = '0;
        tst_ctl         = '0;
        entry_nxt       = 1'b0;
        stdone_nxt      = 1'b0;
        abort_set       = 1'b0;
        run_clr         = 1'b0;
`ifdef MLP_SEQ_TIMEOUT_EN
        tmo_set         = 1'b0;
`endif
        start_pu        = 1'b0;
        rd_sample       = 1'b0;
        done            = 1'b0;
        ld_hidden_layer = '0;
        ld_output_layer = '0;

        case (state)
            ST_IDLE: begin
                done = 1'b1;
                if (start) begin
                    state_nxt   = ST_READ;
                    grp_ctl.clr = 1'b1;
                    tst_ctl.clr = 1'b1;
                    run_clr     = 1'b1;
                end
            end
            ST_READ: begin
                rd_sample = 1'b1;
                if (abort) begin
                    state_nxt   = ST_IDLE;
                    abort_set   = 1'b1;
                    grp_ctl.clr = 1'b1;
                end else if (tst_end) begin
                    state_nxt = ST_IDLE;
                end else begin
                    state_nxt   = ST_HID;
                    grp_ctl.clr = 1'b1;
                    entry_nxt   = 1'b1;
                end
            end
            ST_HID, ST_OUT: begin
                start_pu = (START_PULSE != 0) ? first_q : 1'b1;
                for (int i = 0; i < HID_GROUPS; i++) begin
                    ld_hidden_layer[i] = (state == ST_HID) && (group_index == GRP_W'(i));
                end
                for (int i = 0; i < OUT_GROUPS; i++) begin
                    ld_output_layer[i] = (state == ST_OUT) && (group_index == GRP_W'(i));
                end
                if (abort) begin
                    state_nxt   = ST_IDLE;
                    abort_set   = 1'b1;
                    grp_ctl.clr = 1'b1;
                end else if (ready_pu) begin
                    if (grp_last) begin
                        grp_ctl.clr = 1'b1;
                        if (state == ST_HID) begin
                            state_nxt = ST_OUT;
                            entry_nxt = 1'b1;
                        end else begin
                            state_nxt   = ST_READ;
                            tst_ctl.inc = 1'b1;
                            stdone_nxt  = 1'b1;
                        end
                    end else begin
                        // advancing within a layer is a fresh group entry
                        grp_ctl.inc = 1'b1;
                        entry_nxt   = 1'b1;
                    end
                end
`ifdef MLP_SEQ_TIMEOUT_EN
                else if (wd_hit) begin
                    state_nxt   = ST_IDLE;
                    tmo_set     = 1'b1;
                    grp_ctl.clr = 1'b1;
                end
`endif
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

`ifndef MLP_SEQ_TIMEOUT_EN
    // watchdog compare is constant low in this build
    logic unused_wd;
    assign unused_wd = wd_hit;
`endif

endmodule
